spi_segment_router: RTL and testbench



---
 rtl/spi_segment_router_pkg.sv | 20 ++
 rtl/spi_segment_router_if.sv | 24 ++
 rtl/spi_segment_router_pingpong.sv | 87 ++++++++
 rtl/spi_segment_router.sv | 157 +++++++++++++++
 tb/tb_spi_segment_router.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/spi_segment_router_pkg.sv
// Shared opcodes, error-bit positions and router state encoding for the
// SPI segment router and its record buffer.
package spi_segment_router_pkg;

  localparam logic [7:0] CMD_STATUS      = 8'h01;
  localparam logic [7:0] CMD_CLEAR_ERROR = 8'h02;
  localparam logic [7:0] CMD_WRITE_FIFO  = 8'h10;  // low nibble carries the channel

  localparam int ERR_OVERFLOW    = 0;
  localparam int ERR_BAD_CHANNEL = 1;
  localparam int ERR_UNKNOWN_CMD = 2;

  typedef enum logic [1:0] {
    IDLE,
    STATUS_TX,
    COLLECT,
    DISCARD
  } router_state_e;

endpackage

// File: rtl/spi_segment_router_if.sv
// Byte stream from spi_secondary plus the per-channel FIFO write side.
// The master drives SPI bytes and FIFO occupancy; the slave is the router.
interface spi_segment_router_if #(
  parameter int NumChannels = 4,
  parameter int SizeBits    = 9
);
  logic                            spi_cs;
  logic                            rx_valid;
  logic [7:0]                      rx_data;
  logic [7:0]                      tx_data;
  logic [NumChannels*SizeBits-1:0] fifo_size;
  logic [NumChannels-1:0]          fifo_write_en;
  logic [7:0]                      fifo_data;

  modport master (
    output spi_cs, rx_valid, rx_data, fifo_size,
    input  tx_data, fifo_write_en, fifo_data
  );

  modport slave (
    input  spi_cs, rx_valid, rx_data, fifo_size,
    output tx_data, fifo_write_en, fifo_data
  );
endinterface

// File: rtl/spi_segment_router_pingpong.sv
// Two record buffers: one collects incoming bytes while the other is
// streamed, one byte per clock, into the FIFO of the channel it belongs to.
module record_pingpong_buffer #(
  parameter int NumChannels = 4,
  parameter int RecordWords = 16,
  parameter int IdxBits     = 4,
  parameter int ChBits      = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [IdxBits-1:0]     wr_idx,
  input  logic [7:0]             wr_data,
  input  logic                   commit,
  input  logic [ChBits-1:0]      commit_ch,
  output logic [NumChannels-1:0] fifo_write_en,
  output logic [7:0]             fifo_data,
  output logic                   flushing
);

  logic [7:0]         mem [2][RecordWords];
  logic               collect_ptr;
  logic               flush_ptr;
  logic [1:0]         full;
  logic [ChBits-1:0]  buf_ch [2];
  logic [IdxBits-1:0] flush_idx;
  logic [IdxBits-1:0] next_idx;
  logic               pend_sel;

  assign next_idx = flush_idx + 1'b1;
  assign pend_sel = ~full[0];

  // NOTE: record storage has no reset; the full flags alone decide whether
  // its contents are ever read, so clearing the array would buy nothing.
  always_ff @(posedge clk) begin
    if (wr_en) mem[collect_ptr][wr_idx] <= wr_data;
  end

  // NOTE: all state here is updated with <= so every read in this block sees
  // the pre-edge value, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      collect_ptr   <= 1'b0;
      flush_ptr     <= 1'b0;
      full          <= '0;
      buf_ch[0]     <= '0;
      buf_ch[1]     <= '0;
      flush_idx     <= '0;
      flushing      <= 1'b0;
      fifo_write_en <= '0;
      fifo_data     <= '0;
    end else begin
      if (commit) begin
        full[collect_ptr]   <= 1'b1;
        buf_ch[collect_ptr] <= commit_ch;
        collect_ptr         <= ~collect_ptr;
      end

      if (flushing) begin
        if (flush_idx == IdxBits'(RecordWords - 1)) begin
          flushing        <= 1'b0;
          full[flush_ptr] <= 1'b0;
          fifo_write_en   <= '0;
          fifo_data       <= '0;
        end else begin
          flush_idx <= next_idx;
          fifo_data <= mem[flush_ptr][next_idx];
        end
      end else if (commit) begin
        // Start straight from the completing record to hit one-clock latency;
        // byte 0 bypasses storage when it is the byte arriving right now.
        flushing      <= 1'b1;
        flush_ptr     <= collect_ptr;
        flush_idx     <= '0;
        fifo_write_en <= NumChannels'(1) << commit_ch;
        fifo_data     <= (wr_idx == '0) ? wr_data : mem[collect_ptr][0];
      end else if (|full) begin
        flushing      <= 1'b1;
        flush_ptr     <= pend_sel;
        flush_idx     <= '0;
        fifo_write_en <= NumChannels'(1) << buf_ch[pend_sel];
        fifo_data     <= mem[pend_sel][0];
      end
    end
  end

endmodule

// File: rtl/spi_segment_router.sv
// SPI command front-end: decodes status / segment-write / clear commands and
// routes complete motion records into one of NumChannels segment FIFOs.
module spi_segment_router
  import spi_segment_router_pkg::*;
#(
  parameter int NumChannels = 4,
  parameter int RecordWords = 16,
  parameter int Depth       = 16,
  parameter int SizeBits    = $clog2(Depth * RecordWords) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  spi_segment_router_if.slave  bus,
  output logic [2:0]           error,
  output logic                 busy
);

  localparam int RecShift = $clog2(RecordWords);
  localparam int IdxBits  = (RecordWords > 1) ? $clog2(RecordWords) : 1;
  localparam int ChBits   = (NumChannels > 1) ? $clog2(NumChannels) : 1;
  localparam int OccBits  = SizeBits + 1;

  if (RecordWords < 1 || (RecordWords & (RecordWords - 1)) != 0) begin : g_bad_record_words
    $error("RecordWords must be a power of two");
  end
  if (NumChannels < 1 || NumChannels > 16) begin : g_bad_channels
    $error("NumChannels must be in 1..16");
  end
  if (Depth < 1 || Depth > 255) begin : g_bad_depth
    $error("Depth must be in 1..255");
  end

  router_state_e     state;
  logic [ChBits-1:0] ch;
  logic [IdxBits-1:0] count;
  logic [4:0]        tx_idx;

  logic [7:0]        free_slots [NumChannels];
  logic [7:0]        status_next;
  logic              byte_in;
  logic              is_write;
  logic              ch_ok;
  logic              last_byte;
  logic              wr_en;
  logic              commit;
  logic [2:0]        err_set;
  logic              err_clr;
  logic              flushing;

  // A partially written record still occupies a slot, hence the round-up.
  always_comb begin
    for (int c = 0; c < NumChannels; c++) begin
      logic [OccBits-1:0] recs;
      recs = (OccBits'(bus.fifo_size[c*SizeBits +: SizeBits]) + OccBits'(RecordWords - 1)) >> RecShift;
      free_slots[c] = (recs >= OccBits'(Depth)) ? 8'd0 : 8'(OccBits'(Depth) - recs);
    end
  end

  always_comb begin
    status_next = 8'h00;
    for (int c = 0; c < NumChannels; c++) begin
      if (tx_idx == 5'(c + 1)) status_next = free_slots[c];
    end
  end

  assign byte_in   = bus.rx_valid && !bus.spi_cs;
  assign is_write  = (bus.rx_data[7:4] == CMD_WRITE_FIFO[7:4]);
  assign ch_ok     = (int'(bus.rx_data[3:0]) < NumChannels);
  assign last_byte = (count == IdxBits'(RecordWords - 1));
  assign wr_en     = byte_in && (state == COLLECT);
  assign commit    = wr_en && last_byte && (free_slots[ch] != 8'd0);

  // NOTE: every signal assigned here gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    err_set = '0;
    err_clr = 1'b0;
    if (byte_in && state == IDLE) begin
      if (bus.rx_data == CMD_CLEAR_ERROR)     err_clr = 1'b1;
      else if (is_write && !ch_ok)            err_set[ERR_BAD_CHANNEL] = 1'b1;
      else if (!is_write && bus.rx_data != CMD_STATUS) err_set[ERR_UNKNOWN_CMD] = 1'b1;
    end
    if (wr_en && last_byte && free_slots[ch] == 8'd0) err_set[ERR_OVERFLOW] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      ch          <= '0;
      count       <= '0;
      tx_idx      <= '0;
      error       <= '0;
      bus.tx_data <= free_slots[0];
    end else begin
      error <= err_clr ? 3'b000 : (error | err_set);
      if (bus.spi_cs) begin
        state       <= IDLE;
        count       <= '0;
        bus.tx_data <= free_slots[0];
      end else begin
        unique case (state)
          IDLE: begin
            bus.tx_data <= free_slots[0];
            if (bus.rx_valid) begin
              if (bus.rx_data == CMD_STATUS) begin
                state       <= STATUS_TX;
                tx_idx      <= 5'd1;
                bus.tx_data <= {5'b0, error};
              end else if (is_write && ch_ok) begin
                state       <= COLLECT;
                ch          <= bus.rx_data[ChBits-1:0];
                count       <= '0;
                bus.tx_data <= 8'h00;
              end else if (bus.rx_data != CMD_CLEAR_ERROR) begin
                state       <= DISCARD;
                bus.tx_data <= 8'h00;
              end
            end
          end
          STATUS_TX: begin
            if (bus.rx_valid) begin
              bus.tx_data <= status_next;
              if (tx_idx <= 5'(NumChannels)) tx_idx <= tx_idx + 5'd1;
            end
          end
          COLLECT: begin
            bus.tx_data <= 8'h00;
            if (bus.rx_valid) count <= last_byte ? '0 : count + 1'b1;
          end
          DISCARD: bus.tx_data <= 8'h00;
          default: state <= IDLE;
        endcase
      end
    end
  end

  record_pingpong_buffer #(
    .NumChannels (NumChannels),
    .RecordWords (RecordWords),
    .IdxBits     (IdxBits),
    .ChBits      (ChBits)
  ) u_buffer (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_en         (wr_en),
    .wr_idx        (count),
    .wr_data       (bus.rx_data),
    .commit        (commit),
    .commit_ch     (ch),
    .fifo_write_en (bus.fifo_write_en),
    .fifo_data     (bus.fifo_data),
    .flushing      (flushing)
  );

  assign busy = (state != IDLE) || flushing;

endmodule

// File: tb/tb_spi_segment_router.sv
// Directed bench for spi_segment_router: expected FIFO writes go into a
// scoreboard queue that an independent monitor drains as writes appear.
module tb_spi_segment_router;

  localparam int NCH   = 4;
  localparam int RW    = 16;
  localparam int DEPTH = 16;
  localparam int SB    = $clog2(DEPTH * RW) + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] error;
  logic       busy;

  always #5 clk = ~clk;

  spi_segment_router_if #(.NumChannels(NCH), .SizeBits(SB)) bus ();

  spi_segment_router #(
    .NumChannels (NCH),
    .RecordWords (RW),
    .Depth       (DEPTH),
    .SizeBits    (SB)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .error (error),
    .busy  (busy)
  );

  typedef struct {
    logic [NCH-1:0] mask;
    logic [7:0]     data;
    int             cyc;
  } wr_t;

  wr_t sb[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  last_edge = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every FIFO write must match the oldest expected write.
  always @(negedge clk) begin
    wr_t e;
    if (rst_n && bus.fifo_write_en != '0) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got en=%b data=%0h expected no write (cycle %0d)",
                 bus.fifo_write_en, bus.fifo_data, cyc);
      end else begin
        e = sb.pop_front();
        check("wr_en", 32'(bus.fifo_write_en), 32'(e.mask));
        check("wr_data", 32'(bus.fifo_data), 32'(e.data));
        check("wr_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic send(input logic [7:0] b);
    repeat (15) @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
    last_edge    = cyc;
  endtask

  task automatic send_record(input int ch, input logic [7:0] base, input bit expect_write);
    logic [7:0] b;
    for (int i = 0; i < RW; i++) begin
      b = base + 8'(i);
      send(b);
    end
    if (expect_write) begin
      for (int i = 0; i < RW; i++) begin
        wr_t e;
        e.mask = NCH'(1) << ch;
        e.data = base + 8'(i);
        e.cyc  = last_edge + i;
        sb.push_back(e);
      end
    end
  endtask

  task automatic cs_low();
    @(negedge clk);
    bus.spi_cs = 1'b0;
  endtask

  task automatic cs_high();
    repeat (2) @(negedge clk);
    bus.spi_cs = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic set_size(input int c, input int v);
    bus.fifo_size[c*SB +: SB] = SB'(v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.spi_cs    = 1'b1;
    bus.rx_valid  = 1'b0;
    bus.rx_data   = 8'h00;
    bus.fifo_size = '0;

    // Reset state
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_tx_data", 32'(bus.tx_data), 32'd16);
    check("reset_error", 32'(error), 32'd0);
    check("reset_write_en", 32'(bus.fifo_write_en), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);

    // Single record to channel 1
    cs_low();
    send(8'h11);
    check("collect_busy", 32'(busy), 32'd1);
    send_record(1, 8'hA0, 1'b1);
    cs_high();

    // Status readback with mixed occupancies
    set_size(0, 0);
    set_size(1, 32);
    set_size(2, 256);
    set_size(3, 16);
    cs_low();
    send(8'h01);
    check("status_b0", 32'(bus.tx_data), 32'h00);
    send(8'hFF);
    check("status_b1", 32'(bus.tx_data), 32'd16);
    send(8'hFF);
    check("status_b2", 32'(bus.tx_data), 32'd14);
    send(8'hFF);
    check("status_b3", 32'(bus.tx_data), 32'd0);
    send(8'hFF);
    check("status_b4", 32'(bus.tx_data), 32'd15);
    send(8'hFF);
    check("status_b5", 32'(bus.tx_data), 32'h00);
    cs_high();
    check("idle_tx_free0", 32'(bus.tx_data), 32'd16);

    // Full FIFO: record dropped, overflow flagged, then reported and cleared
    cs_low();
    send(8'h12);
    send_record(2, 8'h60, 1'b0);
    check("overflow_err", 32'(error), 32'b001);
    cs_high();
    cs_low();
    send(8'h01);
    check("status_err", 32'(bus.tx_data), 32'h01);
    cs_high();
    cs_low();
    send(8'h02);
    check("clear_err", 32'(error), 32'b000);
    cs_high();
    for (int c = 0; c < NCH; c++) set_size(c, 0);

    // Aborted partial record leaves nothing behind
    cs_low();
    send(8'h10);
    for (int i = 0; i < 7; i++) send(8'h70 + 8'(i));
    cs_high();
    check("abort_busy", 32'(busy), 32'd0);
    cs_low();
    send(8'h10);
    send_record(0, 8'h00, 1'b1);
    cs_high();
    check("abort_err", 32'(error), 32'b000);

    // Two records in one transaction exercise the buffer swap
    cs_low();
    send(8'h12);
    send_record(2, 8'h30, 1'b1);
    send_record(2, 8'h40, 1'b1);
    cs_high();

    // Bad channel: flagged and the rest of the transaction ignored
    cs_low();
    send(8'h17);
    check("bad_ch_err", 32'(error), 32'b010);
    send(8'h10);
    send_record(0, 8'h80, 1'b0);
    check("discard_tx", 32'(bus.tx_data), 32'h00);
    check("discard_busy", 32'(busy), 32'd1);
    cs_high();

    // Unknown opcode
    cs_low();
    send(8'h55);
    check("unknown_err", 32'(error), 32'b110);
    cs_high();

    // Reset in the middle of a record
    cs_low();
    send(8'h13);
    for (int i = 0; i < 5; i++) send(8'hE0 + 8'(i));
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midreset_err", 32'(error), 32'b000);
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_tx", 32'(bus.tx_data), 32'd16);
    cs_high();
    cs_low();
    send(8'h13);
    send_record(3, 8'hC0, 1'b1);
    cs_high();

    repeat (40) @(negedge clk);
    check("sb_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
